// File: rtl/sram_fault_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sram_fault_pkg
// Description : Fault-slot type and read-path stuck-at helper for the SP SRAM.
// Revision    : 1.0 - initial release
// ============================================================================
package sram_fault_pkg;

    localparam int SRAM_ADDR_W   = 13;
    localparam int SRAM_DATA_W   = 8;
    localparam int SRAM_N_FAULTS = 4;
    localparam int SRAM_BIT_W    = $clog2(SRAM_DATA_W);

    localparam logic FLT_SA0 = 1'b0;
    localparam logic FLT_SA1 = 1'b1;

    typedef struct packed {
        logic                   valid;
        logic                   ftype;
        logic [SRAM_ADDR_W-1:0] addr;
        logic [SRAM_BIT_W-1:0]  bitpos;
    } flt_slot_t;

    // Ascending slot order, so on a shared bit the highest index lands last.
    function automatic logic [SRAM_DATA_W-1:0] apply_faults(
        input logic [SRAM_DATA_W-1:0]               data,
        input logic [SRAM_ADDR_W-1:0]               addr,
        input flt_slot_t [SRAM_N_FAULTS-1:0]        slots
    );
        logic [SRAM_DATA_W-1:0] r;
        r = data;
        for (int i = 0; i < SRAM_N_FAULTS; i++) begin
            if (slots[i].valid && (slots[i].addr == addr)) begin
                r[slots[i].bitpos] = slots[i].ftype;
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sram_sp_array.sv
`default_nettype none
// ============================================================================
// Module      : sram_sp_array
// Description : Plain DEPTH x DW storage, shared 1R/1W port, registered read.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_sp_array #(
    parameter int DW    = 8,
    parameter int DEPTH = 8192,
    parameter int IW    = 13
) (
    input  logic          b_clk,
    input  logic          we_i,
    input  logic          re_i,
    input  logic [IW-1:0] addr_i,
    input  logic [DW-1:0] wdata_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] rdata_q;

    always_ff @(posedge b_clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/sram_sp_fault_model.sv
`default_nettype none
// ============================================================================
// Module      : sram_sp_fault_model
// Description : Single-port SRAM responder with programmable stuck-at faults.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_sp_fault_model
    import sram_fault_pkg::*;
#(
    parameter int ADDR_WIDTH = SRAM_ADDR_W,
    parameter int DATA_WIDTH = SRAM_DATA_W,
    parameter int DEPTH      = 8192,
    parameter int N_FAULTS   = SRAM_N_FAULTS
) (
    input  logic                          b_clk,
    input  logic                          b_rst,
    input  logic [ADDR_WIDTH-1:0]         addr,
    input  logic                          wen,
    input  logic                          cen,
    input  logic                          oen,
    input  logic [DATA_WIDTH-1:0]         d,
    output logic [DATA_WIDTH-1:0]         q,
    input  logic                          flt_wr,
    input  logic [$clog2(N_FAULTS)-1:0]   flt_idx,
    input  logic                          flt_en,
    input  logic                          flt_type,
    input  logic [ADDR_WIDTH-1:0]         flt_addr,
    input  logic [$clog2(DATA_WIDTH)-1:0] flt_bit,
    output logic                          oor_err,
    output logic [31:0]                   wr_cnt,
    output logic [31:0]                   rd_cnt
);

    localparam int                IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH+1)'(DEPTH);

    flt_slot_t [N_FAULTS-1:0] slots_q, slots_d;
    logic [DATA_WIDTH-1:0]    set_q, set_d, clr_q, clr_d;
    logic                     zero_q, zero_d;
    logic                     oor_q, oor_d;
    logic [31:0]              wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;

    logic                     in_range, do_wr, do_rd, oor_hit;
    logic [DATA_WIDTH-1:0]    arr_rdata, q_reg;

    assign in_range = ({1'b0, addr} < DEPTH_L);
    assign do_wr    = !cen && !wen && in_range;
    assign do_rd    = !cen &&  wen && in_range;
    assign oor_hit  = !cen && !in_range;

    always_comb begin
        slots_d  = slots_q;
        set_d    = set_q;
        clr_d    = clr_q;
        zero_d   = zero_q;
        oor_d    = oor_q | oor_hit;
        wr_cnt_d = wr_cnt_q;
        rd_cnt_d = rd_cnt_q;

        if (flt_wr) begin
            slots_d[flt_idx].valid  = flt_en;
            slots_d[flt_idx].ftype  = flt_type;
            slots_d[flt_idx].addr   = flt_addr;
            slots_d[flt_idx].bitpos = flt_bit;
        end

        // Fault masks are latched with the read so the stored word stays true
        // and a same-edge slot update cannot affect this read.
        if (do_rd) begin
            set_d  = apply_faults('0, addr, slots_q);
            clr_d  = ~apply_faults('1, addr, slots_q);
            zero_d = 1'b0;
        end else if (oor_hit && wen) begin
            zero_d = 1'b1;
        end

        if (do_wr && (wr_cnt_q != 32'hFFFF_FFFF)) wr_cnt_d = wr_cnt_q + 32'd1;
        if (do_rd && (rd_cnt_q != 32'hFFFF_FFFF)) rd_cnt_d = rd_cnt_q + 32'd1;
    end

    always_ff @(posedge b_clk) begin
        if (b_rst) begin
            slots_q  <= '0;
            set_q    <= '0;
            clr_q    <= '0;
            zero_q   <= 1'b1;
            oor_q    <= 1'b0;
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
        end else begin
            slots_q  <= slots_d;
            set_q    <= set_d;
            clr_q    <= clr_d;
            zero_q   <= zero_d;
            oor_q    <= oor_d;
            wr_cnt_q <= wr_cnt_d;
            rd_cnt_q <= rd_cnt_d;
        end
    end

    sram_sp_array #(
        .DW    (DATA_WIDTH),
        .DEPTH (DEPTH),
        .IW    (IW)
    ) u_array (
        .b_clk   (b_clk),
        .we_i    (do_wr),
        .re_i    (do_rd),
        .addr_i  (addr[IW-1:0]),
        .wdata_i (d),
        .rdata_o (arr_rdata)
    );

    assign q_reg   = zero_q ? '0 : ((arr_rdata & ~clr_q) | set_q);
    assign q       = oen ? '0 : q_reg;
    assign oor_err = oor_q;
    assign wr_cnt  = wr_cnt_q;
    assign rd_cnt  = rd_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_sram_sp_fault_model.sv
`default_nettype none
// ============================================================================
// Module      : tb_sram_sp_fault_model
// Description : Scoreboard bench for the fault-injecting single-port SRAM.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_sp_fault_model;
    import sram_fault_pkg::*;

    logic        b_clk = 1'b0;
    logic        b_rst = 1'b0;
    logic [12:0] addr  = '0;
    logic        wen   = 1'b1;
    logic        cen   = 1'b1;
    logic        oen   = 1'b0;
    logic [7:0]  d     = '0;
    logic        flt_wr   = 1'b0;
    logic [1:0]  flt_idx  = '0;
    logic        flt_en   = 1'b0;
    logic        flt_type = 1'b0;
    logic [12:0] flt_addr = '0;
    logic [2:0]  flt_bit  = '0;

    logic [7:0]  q_a, q_b;
    logic        oor_a, oor_b;
    logic [31:0] wr_cnt_a, rd_cnt_a, wr_cnt_b, rd_cnt_b;

    sram_sp_fault_model u_dut (
        .b_clk(b_clk), .b_rst(b_rst), .addr(addr), .wen(wen), .cen(cen),
        .oen(oen), .d(d), .q(q_a), .flt_wr(flt_wr), .flt_idx(flt_idx),
        .flt_en(flt_en), .flt_type(flt_type), .flt_addr(flt_addr),
        .flt_bit(flt_bit), .oor_err(oor_a), .wr_cnt(wr_cnt_a), .rd_cnt(rd_cnt_a)
    );

    sram_sp_fault_model #(.DEPTH(4096)) u_dut4k (
        .b_clk(b_clk), .b_rst(b_rst), .addr(addr), .wen(wen), .cen(cen),
        .oen(oen), .d(d), .q(q_b), .flt_wr(flt_wr), .flt_idx(flt_idx),
        .flt_en(flt_en), .flt_type(flt_type), .flt_addr(flt_addr),
        .flt_bit(flt_bit), .oor_err(oor_b), .wr_cnt(wr_cnt_b), .rd_cnt(rd_cnt_b)
    );

    always #5 b_clk = ~b_clk;

    typedef struct {
        logic [7:0] val;
        bit         sel;
        bit         mb;
        string      name;
    } exp_t;

    exp_t sbq[$];
    exp_t pend_e;
    exp_t mon_e;
    bit   pend   = 1'b0;
    bit   chk    = 1'b0;
    bit   b_fail = 1'b0;
    bit   b_done = 1'b0;
    int   n_chk  = 0;
    int   n_fail = 0;
    logic [7:0] mon_act;

    // q is compared mid-cycle against whatever expectation the stimulus queued.
    always @(negedge b_clk) begin
        if (chk) begin
            if (sbq.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL sb_underflow: check strobe with empty queue, required one entry");
            end else begin
                mon_e   = sbq.pop_front();
                mon_act = mon_e.sel ? q_b : q_a;
                if (mon_e.mb) begin
                    if (mon_act !== mon_e.val) b_fail = 1'b1;
                end else begin
                    n_chk++;
                    if (mon_act !== mon_e.val) begin
                        n_fail++;
                        $display("FAIL %s: q=%02h required %02h", mon_e.name, mon_act, mon_e.val);
                    end
                end
            end
        end
    end

    task automatic expect_next(input logic [7:0] v, input bit s, input bit m, input string n);
        pend        = 1'b1;
        pend_e.val  = v;
        pend_e.sel  = s;
        pend_e.mb   = m;
        pend_e.name = n;
    endtask

    task automatic step(input logic c, input logic w, input logic [12:0] a, input logic [7:0] dd);
        cen  = c;
        wen  = w;
        addr = a;
        d    = dd;
        if (pend) begin
            sbq.push_back(pend_e);
            chk  = 1'b1;
            pend = 1'b0;
        end else begin
            chk = 1'b0;
        end
        @(posedge b_clk);
        #1;
        flt_wr = 1'b0;
        b_rst  = 1'b0;
        chk    = 1'b0;
    endtask

    task automatic idle();
        step(1'b1, 1'b1, 13'h0, 8'h00);
    endtask

    task automatic wr(input logic [12:0] a, input logic [7:0] dd);
        step(1'b0, 1'b0, a, dd);
    endtask

    task automatic rdx(input logic [12:0] a, input logic [7:0] v, input bit s, input bit m, input string n);
        step(1'b0, 1'b1, a, 8'h00);
        expect_next(v, s, m, n);
    endtask

    task automatic set_flt(input logic [1:0] i, input logic en, input logic t,
                           input logic [12:0] a, input logic [2:0] b);
        flt_wr   = 1'b1;
        flt_idx  = i;
        flt_en   = en;
        flt_type = t;
        flt_addr = a;
        flt_bit  = b;
    endtask

    task automatic prog(input logic [1:0] i, input logic en, input logic t,
                        input logic [12:0] a, input logic [2:0] b);
        set_flt(i, en, t, a, b);
        idle();
    endtask

    task automatic check32(input string n, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", n, act, req);
        end
    endtask

    // March: up w00; up (r00,wFF); down (rFF,w00); up r00.
    task automatic march(input int lo, input int hi);
        b_fail = 1'b0;
        b_done = 1'b0;
        for (int a = lo; a <= hi; a++) wr(13'(a), 8'h00);
        for (int a = lo; a <= hi; a++) begin
            rdx(13'(a), 8'h00, 1'b0, 1'b1, "m1");
            wr(13'(a), 8'hFF);
        end
        for (int a = hi; a >= lo; a--) begin
            rdx(13'(a), 8'hFF, 1'b0, 1'b1, "m2");
            wr(13'(a), 8'h00);
        end
        for (int a = lo; a <= hi; a++) rdx(13'(a), 8'h00, 1'b0, 1'b1, "m3");
        idle();
        b_done = 1'b1;
    endtask

    initial begin
        b_rst = 1'b1;
        idle();
        check32("rst_wr_cnt", wr_cnt_a, 32'd0);
        check32("rst_rd_cnt", rd_cnt_a, 32'd0);
        check32("rst_oor", {31'd0, oor_a}, 32'd0);
        expect_next(8'h00, 1'b0, 1'b0, "rst_q");

        wr(13'h0010, 8'hA5);
        rdx(13'h0010, 8'hA5, 1'b0, 1'b0, "basic_rd");
        idle();
        check32("basic_wr_cnt", wr_cnt_a, 32'd1);
        check32("basic_rd_cnt", rd_cnt_a, 32'd1);

        prog(2'd0, 1'b1, FLT_SA0, 13'h1FFF, 3'd3);
        wr(13'h1FFF, 8'hFF);
        rdx(13'h1FFF, 8'hF7, 1'b0, 1'b0, "sa0_bit3");
        set_flt(2'd0, 1'b0, FLT_SA0, 13'h1FFF, 3'd3);
        rdx(13'h1FFF, 8'hF7, 1'b0, 1'b0, "flt_same_edge");
        rdx(13'h1FFF, 8'hFF, 1'b0, 1'b0, "flt_cleared");
        idle();

        prog(2'd1, 1'b1, FLT_SA1, 13'h0005, 3'd0);
        prog(2'd2, 1'b1, FLT_SA0, 13'h0005, 3'd0);
        wr(13'h0005, 8'h00);
        rdx(13'h0005, 8'h00, 1'b0, 1'b0, "prio_on_00");
        wr(13'h0005, 8'hFF);
        rdx(13'h0005, 8'hFE, 1'b0, 1'b0, "prio_on_ff");
        idle();

        wr(13'h0020, 8'h5A);
        oen = 1'b1;
        rdx(13'h0020, 8'h00, 1'b0, 1'b0, "oen_gated");
        idle();
        oen = 1'b0;
        expect_next(8'h5A, 1'b0, 1'b0, "oen_release");
        idle();

        b_rst = 1'b1;
        idle();
        wr(13'h0001, 8'h11);
        rdx(13'h0001, 8'h11, 1'b1, 1'b0, "oor_pre_rd");
        wr(13'h1000, 8'h3C);
        check32("oor_set", {31'd0, oor_b}, 32'd1);
        check32("oor_wr_cnt", wr_cnt_b, 32'd1);
        check32("inrange_no_oor", {31'd0, oor_a}, 32'd0);
        rdx(13'h1000, 8'h00, 1'b1, 1'b0, "oor_rd_zero");
        idle();
        check32("oor_rd_cnt", rd_cnt_b, 32'd1);
        check32("oor_sticky", {31'd0, oor_b}, 32'd1);
        b_rst = 1'b1;
        idle();
        check32("oor_rst", {31'd0, oor_b}, 32'd0);

        march(32'h0A00, 32'h0BFF);
        check32("mbist_clean_done", {31'd0, b_done}, 32'd1);
        check32("mbist_clean_fail", {31'd0, b_fail}, 32'd0);
        prog(2'd0, 1'b1, FLT_SA1, 13'h0ABC, 3'd7);
        march(32'h0A00, 32'h0BFF);
        check32("mbist_fault_fail", {31'd0, b_fail}, 32'd1);

        prog(2'd0, 1'b1, FLT_SA1, 13'h0B10, 3'd7);
        for (int a = 32'h0A00; a <= 32'h0BFF; a++) wr(13'(a), 8'h00);
        for (int a = 32'h0A00; a < 32'h0B00; a++) begin
            rdx(13'(a), 8'h00, 1'b0, 1'b1, "mr1");
            wr(13'(a), 8'hFF);
        end
        rdx(13'h0ABC, 8'hFF, 1'b0, 1'b0, "pre_rst_rd");
        set_flt(2'd3, 1'b1, FLT_SA0, 13'h0ABC, 3'd0);
        b_rst = 1'b1;
        idle();
        expect_next(8'h00, 1'b0, 1'b0, "midmarch_rst_q");
        check32("midmarch_wr_cnt", wr_cnt_a, 32'd0);
        check32("midmarch_rd_cnt", rd_cnt_a, 32'd0);
        rdx(13'h0B10, 8'h00, 1'b0, 1'b0, "rst_slot_clr");
        rdx(13'h0ABC, 8'hFF, 1'b0, 1'b0, "rst_beats_flt_wr");
        idle();
        idle();

        check32("sb_drain", sbq.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
